mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter placed between two L2 cache instances (instruction side on port 0, data side on port 1) and the single main-memory port. It grants one requester at a time. A burst stays locked to its owner until the owner releases it or hits a beat cap. The losing requester is held with a per-port wait signal. Memory read data is returned to both ports, and only the granted port may sample it.

## Interface
- AW, 32: address width.
- DW, 32: data width.
- MAX_BEATS, 16: maximum consecutive granted beats while the other port is requesting; must be ≥ 2.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- p0_renable  input  1  port 0 read request, held until served.
- p0_wenable  input  1  port 0 write request, held until served.
- p0_addr  input  AW  port 0 address.
- p0_wdata  input  DW  port 0 write data.
- p0_rdata  output  DW  memory read data (mem_rdata pass-through).
- p0_wait  output  1  1 = port 0 not granted this cycle; requester must hold its request and not advance.
- p1_renable, p1_wenable, p1_addr, p1_wdata, p1_rdata, p1_wait: same as port 0, for port 1.
- mem_renable  output  1  memory read enable.
- mem_wenable  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid in the same cycle as mem_addr.
- owner  output  2  debug: 2'b00 idle, 2'b01 port 0, 2'b10 port 1.

## Operation
- reqN = pN_renable | pN_wenable.
- States:
  - IDLE: no owner.
  - OWN0: port 0 owns memory.
  - OWN1: port 1 owns memory.
- Registers: state, last_owner (1 bit), beat_cnt (width clog2(MAX_BEATS)).
- IDLE transitions:
  - only req0 → OWN0.
  - only req1 → OWN1.
  - both requesting → the port ≠ last_owner (round-robin).
  - no request → stay in IDLE.
- OWNn transitions:
  - owner drops reqn, other port requesting → OWN(other) directly (no IDLE bubble).
  - owner drops reqn, other port not requesting → IDLE.
  - owner keeps reqn, beat_cnt == MAX_BEATS-1, other port requesting → OWN(other); this is the preemption point.
  - otherwise → stay.
- last_owner: updated to the new owner on every entry into OWN0/OWN1.
- beat_cnt:
  - cleared to 0 on every state change.
  - incremented on each cycle in OWNn with reqn=1.
  - saturates at MAX_BEATS-1 while the other port is not requesting (lock holds indefinitely).
- Output mux, combinational from state:
  - In OWNn with reqn=1: mem_* = port n's signals.
  - If port n asserts wenable and renable together, mem_wenable=1 and mem_renable=0 (write precedence).
  - In IDLE, or in OWNn with reqn=0: mem_renable=mem_wenable=0, mem_addr=0, mem_wdata=0.
- Wait outputs:
  - pN_wait = reqN & !(state==OWNN).
  - A non-requesting port sees wait=0.
- Read data: p0_rdata = p1_rdata = mem_rdata at all times.

## Timing
- Reset (rst=0 at an edge) forces:
  - state=IDLE, last_owner=1 (port 0 wins the first tie), beat_cnt=0.
  - owner=00, both waits 0 unless requesting.
  - all mem_* outputs 0.
- Reset asserted mid-burst: the burst is abandoned at that edge. The requester re-requests and is arbitrated afresh after reset.
- Grant latency:
  - One cycle from request in IDLE: the request-arrival cycle has pN_wait=1 and the next cycle is the first beat.
  - Zero bubble on handoff between owners.
- A beat completes at the rising edge ending a cycle where pN_wait=0 and reqN=1. The requester samples pN_rdata at that edge.
- Preemption: at most MAX_BEATS beats per grant while contended. The preempted port sees wait=1 in the cycle immediately after its last beat.
- Starvation bound: a waiting port is granted within MAX_BEATS+1 cycles.

## Configuration
- MEMARB_FIXED_PRIO_EN defined:
  - port 0 always wins ties in IDLE and at release.
  - port 1 cannot preempt port 0 (beat cap ignored when port 0 owns); port 0 still preempts port 1 at the cap.
  - last_owner unused.
- Undefined: round-robin and symmetric beat cap as above.

## Test plan
- Reset with p0_renable=1 held → all mem_* 0, owner=00 during reset. First cycle after release: p0_wait=1. Next cycle: owner=01, mem_addr=p0_addr, mem_renable=1.
- Both ports request in IDLE after reset → OWN0 first. After port 0 drops its request, next cycle owner=10 with no idle cycle; the following tie goes to port 0 again (round-robin).
- Port 0 holds a 20-beat read burst while port 1 requests from cycle 1 (MAX_BEATS=16) → exactly 16 beats with p0_wait=0, then owner=10 and p0_wait=1.
- Port 1 write with p1_wenable=1, p1_addr=0x100, p1_wdata=0xDEADBEEF, p0 idle → after 1 wait cycle, mem_wenable=1, mem_addr=0x100, mem_wdata=0xDEADBEEF for one cycle.
- Port 0 asserts renable and wenable together while owning → mem_wenable=1, mem_renable=0.
- MEMARB_FIXED_PRIO_EN defined, port 0 bursts 40 beats with port 1 requesting → port 1 waits all 40 beats and is granted on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: L2-I on port 0, L2-D on port 1, one main-memory port; grant after 1 idle cycle, zero-bubble handoff.
// Losers see pN_wait=1 and hold their request; contended bursts are capped at MAX_BEATS. Define MEMARB_FIXED_PRIO_EN for fixed port-0 priority.
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_renable,
   input  logic          p0_wenable,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_wait,
   input  logic          p1_renable,
   input  logic          p1_wenable,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_wait,
   output logic          mem_renable,
   output logic          mem_wenable,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
);

   localparam int CW = $clog2(MAX_BEATS);
   localparam logic [CW-1:0] CAP = CW'(MAX_BEATS - 1);

   // Encodings double as the debug owner code.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] beat_cnt;
   logic          req0;
   logic          req1;
   logic          own_req;
   logic          at_cap;
   logic          pick0;
   logic          cap0_en;

   assign req0    = p0_renable | p0_wenable;
   assign req1    = p1_renable | p1_wenable;
   assign own_req = ((state == OWN0) && req0) || ((state == OWN1) && req1);
   assign at_cap  = (beat_cnt == CAP);

`ifdef MEMARB_FIXED_PRIO_EN
   assign pick0   = req0;
   assign cap0_en = 1'b0;
`else
   logic last_owner;

   // Tie goes to whichever port did not own memory last.
   assign pick0   = req0 & (~req1 | last_owner);
   assign cap0_en = 1'b1;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (req0 || req1)
               nxt = pick0 ? OWN0 : OWN1;
         end
         OWN0: begin
            if (!req0)
               nxt = req1 ? OWN1 : IDLE;
            else if (cap0_en && at_cap && req1)
               nxt = OWN1;
         end
         OWN1: begin
            if (!req1)
               nxt = req0 ? OWN0 : IDLE;
            else if (at_cap && req0)
               nxt = OWN0;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
         last_owner <= 1'b1;
`endif
      end else begin
         state <= nxt;
         if (nxt != state)
            beat_cnt <= '0;
         else if (own_req && !at_cap)
            beat_cnt <= beat_cnt + 1'b1;
`ifndef MEMARB_FIXED_PRIO_EN
         if (nxt != state && nxt != IDLE)
            last_owner <= (nxt == OWN1);
`endif
      end
   end

   // A port asserting both enables gets a write; its read waits for a later beat.
   always_comb begin
      mem_renable = 1'b0;
      mem_wenable = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (own_req) begin
         if (state == OWN1) begin
            mem_wenable = p1_wenable;
            mem_renable = p1_renable & ~p1_wenable;
            mem_addr    = p1_addr;
            mem_wdata   = p1_wdata;
         end else begin
            mem_wenable = p0_wenable;
            mem_renable = p0_renable & ~p0_wenable;
            mem_addr    = p0_addr;
            mem_wdata   = p0_wdata;
         end
      end
   end

   assign p0_wait  = req0 & (state != OWN0);
   assign p1_wait  = req1 & (state != OWN1);
   assign p0_rdata = mem_rdata;
   assign p1_rdata = mem_rdata;
   assign owner    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, grant latency, handoff, round-robin, beat cap, write precedence.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_renable, p0_wenable, p1_renable, p1_wenable;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        p0_wait, p1_wait, mem_renable, mem_wenable;
   logic [1:0]  owner;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_BEATS(16)) dut (
      .clk(clk), .rst(rst),
      .p0_renable(p0_renable), .p0_wenable(p0_wenable), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_wait(p0_wait),
      .p1_renable(p1_renable), .p1_wenable(p1_wenable), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_wait(p1_wait),
      .mem_renable(mem_renable), .mem_wenable(mem_wenable), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int beats;
   int waits;

   initial begin
      rst = 1'b0;
      p0_renable = 1'b1; p0_wenable = 1'b0; p0_addr = 32'h40; p0_wdata = '0;
      p1_renable = 1'b0; p1_wenable = 1'b0; p1_addr = '0;    p1_wdata = '0;
      mem_rdata = '0;

      // Reset with port 0 requesting
      cyc(); settle();
      chk("rst_owner", owner, 2'b00);
      chk("rst_mem_ren", mem_renable, 1'b0);
      chk("rst_mem_wen", mem_wenable, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_p1_wait", p1_wait, 1'b0);
      cyc(); rst = 1'b1; settle();
      chk("lat_p0_wait", p0_wait, 1'b1);
      chk("lat_owner_idle", owner, 2'b00);
      cyc(); settle();
      chk("lat_owner", owner, 2'b01);
      chk("lat_mem_addr", mem_addr, 32'h40);
      chk("lat_mem_ren", mem_renable, 1'b1);
      chk("lat_p0_wait_gnt", p0_wait, 1'b0);
      mem_rdata = 32'h1234_5678; settle();
      chk("rdata_p0", p0_rdata, 32'h1234_5678);
      chk("rdata_p1", p1_rdata, 32'h1234_5678);
      p0_renable = 1'b0; settle();
      chk("drop_mem_ren", mem_renable, 1'b0);
      cyc(); settle();
      chk("release_idle", owner, 2'b00);

      // Tie after reset, zero-bubble handoff, then round-robin tie
      rst = 1'b0; cyc(); rst = 1'b1;
      p0_renable = 1'b1; p1_renable = 1'b1; p1_addr = 32'h80; settle();
      chk("tie_p0_wait", p0_wait, 1'b1);
      chk("tie_p1_wait", p1_wait, 1'b1);
      cyc(); settle();
      chk("tie_owner0", owner, 2'b01);
      chk("tie_p1_held", p1_wait, 1'b1);
      p0_renable = 1'b0; settle();
      chk("handoff_p1_wait", p1_wait, 1'b1);
      cyc(); settle();
      chk("handoff_owner1", owner, 2'b10);
      chk("handoff_addr", mem_addr, 32'h80);
      chk("handoff_p1_wait", p1_wait, 1'b0);
      p1_renable = 1'b0; cyc();
      p0_renable = 1'b1; p1_renable = 1'b1; settle();
      chk("rr_idle", owner, 2'b00);
      cyc(); settle();
      chk("rr_owner0", owner, 2'b01);

      // Reset mid-burst abandons the grant
      rst = 1'b0; cyc(); settle();
      chk("midrst_owner", owner, 2'b00);
      chk("midrst_mem_ren", mem_renable, 1'b0);
      rst = 1'b1; p0_renable = 1'b0; p1_renable = 1'b0; cyc();

`ifndef MEMARB_FIXED_PRIO_EN
      // 20-beat burst contended from the first beat: capped at 16
      p0_renable = 1'b1; p0_addr = 32'h1000; cyc();
      p1_renable = 1'b1;
      beats = 0;
      for (int i = 0; i < 20; i++) begin
         settle();
         if (p0_wait == 1'b0) beats++;
         if (i == 16) begin
            chk("cap_owner1", owner, 2'b10);
            chk("cap_p0_wait", p0_wait, 1'b1);
         end
         p0_addr = p0_addr + 32'd4;
         cyc();
      end
      chk("cap_beats", beats, 16);
      p0_renable = 1'b0; p1_renable = 1'b0; cyc(); settle();
      chk("cap_idle", owner, 2'b00);

      // Uncontended lock holds past the cap; late contender preempts at once
      p0_renable = 1'b1; cyc();
      for (int i = 0; i < 20; i++) cyc();
      settle();
      chk("sat_owner0", owner, 2'b01);
      p1_renable = 1'b1; cyc(); settle();
      chk("sat_preempt", owner, 2'b10);
      p0_renable = 1'b0; p1_renable = 1'b0; cyc();
`else
      // Fixed priority: port 1 cannot preempt a 40-beat port 0 burst
      p0_renable = 1'b1; p1_renable = 1'b1; cyc();
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         settle();
         if (p1_wait == 1'b1 && owner == 2'b01) waits++;
         cyc();
      end
      chk("fix_waits", waits, 40);
      p0_renable = 1'b0; cyc(); settle();
      chk("fix_owner1", owner, 2'b10);
      p1_renable = 1'b0; cyc();
`endif

      // Port 1 write
      p1_wenable = 1'b1; p1_addr = 32'h100; p1_wdata = 32'hDEAD_BEEF; settle();
      chk("wr_p1_wait", p1_wait, 1'b1);
      chk("wr_wen_pre", mem_wenable, 1'b0);
      cyc(); settle();
      chk("wr_owner", owner, 2'b10);
      chk("wr_wen", mem_wenable, 1'b1);
      chk("wr_ren", mem_renable, 1'b0);
      chk("wr_addr", mem_addr, 32'h100);
      chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      p1_wenable = 1'b0; cyc(); settle();
      chk("wr_done", mem_wenable, 1'b0);

      // Write precedence when both enables are set
      p0_renable = 1'b1; p0_wenable = 1'b1; p0_addr = 32'h200; p0_wdata = 32'hCAFE;
      cyc(); settle();
      chk("prec_wen", mem_wenable, 1'b1);
      chk("prec_ren", mem_renable, 1'b0);
      chk("prec_wdata", mem_wdata, 32'hCAFE);
      p0_renable = 1'b0; p0_wenable = 1'b0; cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
